// File: rtl/downsampler.sv
// Decimation stage of a CIC decimator: picks every rate_active-th input sample
// and forwards it to the comb section. The ratio can be changed at run time.
// A new ratio is held as pending and takes effect only at a frame boundary
// (wrap or phase_sync), so a frame never mixes two ratios.
module downsampler #(
    parameter  int SAMP_WIDTH = 8,
    parameter  int CIC_R_MAX  = 16,
    parameter  int CIC_R      = 4,
    localparam int RW         = $clog2(CIC_R_MAX + 1)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [SAMP_WIDTH-1:0] samp_inp_data,
    input  logic                  samp_inp_str,
    input  logic [RW-1:0]         rate_data,
    input  logic                  rate_str,
    input  logic                  phase_sync,
    output logic [SAMP_WIDTH-1:0] samp_out_data,
    output logic                  samp_out_str,
    output logic [RW-1:0]         rate_active,
    output logic                  rate_pending
);

    logic [RW-1:0] cnt;
    logic [RW-1:0] rate_pend;
    logic [RW-1:0] rate_san;
    logic [RW-1:0] rate_next;
    logic          wrap_norm;
    logic          wrap_sync;
    logic          wrap;
    logic          boundary;

    // Clamp the requested ratio into 1..CIC_R_MAX before it is stored.
    always_comb begin
        rate_san = rate_data;
        if (rate_data == '0)
            rate_san = RW'(1);
        else if (rate_data > RW'(CIC_R_MAX))
            rate_san = RW'(CIC_R_MAX);
    end

    // Ratio for the frame starting at a boundary: a same-cycle request beats
    // an older pending one, which beats the current ratio.
    always_comb begin
        rate_next = rate_active;
        if (rate_str)
            rate_next = rate_san;
        else if (rate_pending)
            rate_next = rate_pend;
        // A strobe alongside phase_sync is sample 1 of the new frame; with a
        // new ratio of 1 that sample is itself the frame end.
        wrap_norm = samp_inp_str && !phase_sync && (cnt == rate_active - RW'(1));
        wrap_sync = samp_inp_str && phase_sync && (rate_next == RW'(1));
        wrap      = wrap_norm || wrap_sync;
        boundary  = phase_sync || wrap_norm;
    end

    // Phase counter within the current frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt <= '0;
        else if (wrap)
            cnt <= '0;
        else if (phase_sync)
            cnt <= samp_inp_str ? RW'(1) : RW'(0);
        else if (samp_inp_str)
            cnt <= cnt + RW'(1);
    end

    // Output register: capture the frame-end sample, pulse the strobe once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            samp_out_data <= '0;
            samp_out_str  <= 1'b0;
        end else begin
            samp_out_str <= wrap;
            if (wrap)
                samp_out_data <= samp_inp_data;
        end
    end

    // Ratio bookkeeping: latch requests, apply them at frame boundaries.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rate_active  <= RW'(CIC_R);
            rate_pend    <= RW'(CIC_R);
            rate_pending <= 1'b0;
        end else if (boundary) begin
            rate_active  <= rate_next;
            rate_pending <= 1'b0;
            if (rate_str)
                rate_pend <= rate_san;
        end else if (rate_str) begin
            rate_pend    <= rate_san;
            rate_pending <= 1'b1;
        end
    end

endmodule

// File: tb/tb_downsampler.sv
// Self-checking bench for downsampler: scoreboard of expected output samples
// with their expected cycle, a table of ratio clamp vectors, and hand-written
// sequences for boundary, phase_sync and reset corner cases.
module tb_downsampler;

    localparam int SW   = 8;
    localparam int RMAX = 16;
    localparam int R0   = 4;
    localparam int RW   = $clog2(RMAX + 1);

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [SW-1:0] samp_inp_data = '0;
    logic          samp_inp_str = 1'b0;
    logic [RW-1:0] rate_data = '0;
    logic          rate_str = 1'b0;
    logic          phase_sync = 1'b0;
    logic [SW-1:0] samp_out_data;
    logic          samp_out_str;
    logic [RW-1:0] rate_active;
    logic          rate_pending;

    downsampler #(.SAMP_WIDTH(SW), .CIC_R_MAX(RMAX), .CIC_R(R0)) dut (
        .clk(clk), .reset_n(reset_n),
        .samp_inp_data(samp_inp_data), .samp_inp_str(samp_inp_str),
        .rate_data(rate_data), .rate_str(rate_str), .phase_sync(phase_sync),
        .samp_out_data(samp_out_data), .samp_out_str(samp_out_str),
        .rate_active(rate_active), .rate_pending(rate_pending)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [SW-1:0] d;
        int            c;
    } exp_t;

    typedef struct {
        logic [RW-1:0] req;
        logic [RW-1:0] act;
    } vec_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock of stimulus; ex pushes d as the output expected next cycle.
    task automatic step(input bit s, input logic [SW-1:0] d, input bit rs,
                        input logic [RW-1:0] rd, input bit ps, input bit ex);
        exp_t e;
        samp_inp_str  = s;
        samp_inp_data = d;
        rate_str      = rs;
        rate_data     = rd;
        phase_sync    = ps;
        if (ex) begin
            e.d = d;
            e.c = cyc + 1;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        samp_inp_str = 1'b0;
        rate_str     = 1'b0;
        phase_sync   = 1'b0;
    endtask

    task automatic smp(input logic [SW-1:0] d, input bit ex);
        step(1'b1, d, 1'b0, '0, 1'b0, ex);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic set_rate(input logic [RW-1:0] r);
        step(1'b0, '0, 1'b1, r, 1'b1, 1'b0);
    endtask

    initial begin
        vec_t vt[7];
        exp_t e;
        vt[0] = '{req: 5'd0,  act: 5'd1};
        vt[1] = '{req: 5'd1,  act: 5'd1};
        vt[2] = '{req: 5'd2,  act: 5'd2};
        vt[3] = '{req: 5'd16, act: 5'd16};
        vt[4] = '{req: 5'd17, act: 5'd16};
        vt[5] = '{req: 5'd19, act: 5'd16};
        vt[6] = '{req: 5'd31, act: 5'd16};

        // Output monitor: every strobe must match the scoreboard head.
        fork
            forever begin
                @(negedge clk);
                if (reset_n && samp_out_str) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_out: got data %0d at cycle %0d expected no strobe",
                                 samp_out_data, cyc);
                    end else begin
                        e = sb.pop_front();
                        chk("out_data", samp_out_data, e.d);
                        chk("out_cycle", cyc, e.c);
                    end
                end
            end
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data", samp_out_data, 0);
        chk("rst_str", samp_out_str, 0);
        chk("rst_rate", rate_active, R0);
        chk("rst_pend", rate_pending, 0);
        reset_n = 1'b1;
        idle(2);

        // Basic decimation by 4: outputs 4, 8, 12
        for (int i = 1; i <= 12; i++) smp(SW'(i), (i % 4) == 0);
        idle(2);

        // Sparse strobes at ratio 3, output held afterwards
        set_rate(5'd3);
        chk("r3_active", rate_active, 3);
        smp(-8'sd5, 1'b0); idle(4);
        smp(-8'sd6, 1'b0); idle(4);
        smp(-8'sd7, 1'b1); idle(4);
        chk("hold_data", samp_out_data, 8'hF9);
        chk("hold_str", samp_out_str, 0);

        // Mid-frame rate change 4 -> 2
        set_rate(5'd4);
        smp(8'd1, 1'b0);
        step(1'b0, '0, 1'b1, 5'd2, 1'b0, 1'b0);
        chk("mid_pend", rate_pending, 1);
        chk("mid_act_old", rate_active, 4);
        smp(8'd2, 1'b0);
        smp(8'd3, 1'b0);
        chk("mid_pend_held", rate_pending, 1);
        smp(8'd4, 1'b1);
        chk("mid_act_new", rate_active, 2);
        chk("mid_pend_clr", rate_pending, 0);
        for (int i = 5; i <= 8; i++) smp(SW'(i), (i % 2) == 0);
        idle(2);

        // Clamp table: request stays pending until phase_sync applies it
        for (int i = 0; i < 7; i++) begin
            step(1'b0, '0, 1'b1, vt[i].req, 1'b0, 1'b0);
            chk($sformatf("tbl%0d_pend", i), rate_pending, 1);
            step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
            chk($sformatf("tbl%0d_act", i), rate_active, vt[i].act);
            chk($sformatf("tbl%0d_clr", i), rate_pending, 0);
        end

        // Ratio 0 clamps to 1: every sample forwarded
        set_rate(5'd0);
        chk("r1_active", rate_active, 1);
        for (int i = 10; i < 14; i++) smp(SW'(i), 1'b1);
        idle(2);

        // Last request wins
        step(1'b0, '0, 1'b1, 5'd5, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 5'd7, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        chk("last_wins", rate_active, 7);

        // rate_str on the wrap strobe applies to the next frame directly
        set_rate(5'd2);
        smp(8'd21, 1'b0);
        step(1'b1, 8'd22, 1'b1, 5'd3, 1'b0, 1'b1);
        chk("wrap_rs_pend", rate_pending, 0);
        chk("wrap_rs_act", rate_active, 3);
        for (int i = 23; i <= 25; i++) smp(SW'(i), i == 25);
        idle(2);

        // phase_sync with strobe starts a new frame at sample 2
        set_rate(5'd4);
        smp(8'd1, 1'b0);
        step(1'b1, 8'd2, 1'b0, '0, 1'b1, 1'b0);
        for (int i = 3; i <= 9; i++) smp(SW'(i), (i == 5) || (i == 9));
        idle(2);

        // phase_sync + rate 1 + strobe is an immediate wrap
        step(1'b1, 8'h33, 1'b1, 5'd1, 1'b1, 1'b1);
        idle(2);

        // Reset while the output strobe is high
        set_rate(5'd3);
        smp(8'd1, 1'b0);
        smp(8'd2, 1'b0);
        smp(8'd3, 1'b0);
        chk("pre_rst_str", samp_out_str, 1);
        chk("pre_rst_data", samp_out_data, 3);
        reset_n = 1'b0;
        #1;
        chk("async_str", samp_out_str, 0);
        chk("async_data", samp_out_data, 0);
        chk("async_rate", rate_active, R0);
        chk("async_pend", rate_pending, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int i = 1; i <= 4; i++) smp(SW'(40 + i), i == 4);
        idle(3);

        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/downsampler.md
DOWNSAMPLER -- requirements
Module: downsampler

Interface
REQ-001 SHALL have parameter SAMP_WIDTH, default 8, the sample width in bits, signed.
REQ-002 SHALL have parameter CIC_R_MAX, default 16, the largest supported decimation ratio (at least 1).
REQ-003 SHALL have parameter CIC_R, default 4, the decimation ratio after reset (1..CIC_R_MAX).
REQ-004 SHALL define RW = $clog2(CIC_R_MAX+1) as the width of every ratio field.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port samp_inp_data, input, SAMP_WIDTH bits: signed input sample from the integrator chain.
REQ-008 SHALL have port samp_inp_str, input, 1 bit: input sample valid for one clk.
REQ-009 SHALL have port rate_data, input, RW bits: requested decimation ratio.
REQ-010 SHALL have port rate_str, input, 1 bit: rate_data valid for one clk.
REQ-011 SHALL have port phase_sync, input, 1 bit: restart the decimation frame.
REQ-012 SHALL have port samp_out_data, output, SAMP_WIDTH bits: decimated sample, to be fed to the first comb stage.
REQ-013 SHALL have port samp_out_str, output, 1 bit: decimated sample valid for one clk.
REQ-014 SHALL have port rate_active, output, RW bits: the ratio currently in force.
REQ-015 SHALL have port rate_pending, output, 1 bit: an accepted ratio is waiting to be applied.

Function
REQ-016 SHALL keep a phase counter cnt (0..rate_active-1) that increments on each samp_inp_str.
REQ-017 SHALL treat an input strobe with cnt == rate_active-1 as the frame end ("wrap"): cnt goes to 0, samp_inp_data is registered into samp_out_data, and samp_out_str is asserted the next cycle.
REQ-018 SHALL have a latency of exactly 1 clk from the wrap strobe to samp_out_str; samp_out_str is high for 1 clk per wrap and low otherwise.
REQ-019 SHALL hold samp_out_data between wraps.
REQ-020 SHALL output every input sample when rate_active == 1 (one output per input strobe, 1 clk later).
REQ-021 SHALL sanitise rate_data on rate_str before it is stored: 0 becomes 1, values above CIC_R_MAX become CIC_R_MAX.
REQ-022 SHALL latch the sanitised value into a pending register on rate_str and set rate_pending.
REQ-023 SHALL keep only the last request (last request wins) when rate_str arrives again while pending.
REQ-024 SHALL apply a pending ratio only at a frame boundary (wrap or phase_sync); at that point rate_active takes the pending value and rate_pending clears in the same edge.
REQ-025 SHALL, when rate_str coincides with a wrap, apply the new ratio directly to the frame starting next; rate_pending is never visibly asserted in that case.
REQ-026 SHALL, on phase_sync without an input strobe, set cnt to 0, apply any pending ratio, and emit no output.
REQ-027 SHALL, when phase_sync and samp_inp_str coincide, count the strobe as the first sample of the new frame: cnt goes to 1, or it is a wrap producing output if the new ratio is 1.
REQ-028 SHALL, when phase_sync and rate_str coincide, apply the new rate_str value immediately.
REQ-029 SHALL pass samples through bit-exactly, with no arithmetic, truncation or sign change.

Reset
REQ-030 SHALL, while reset_n is low (asynchronous assert, synchronous release), force samp_out_data = 0, samp_out_str = 0, cnt = 0, rate_active = CIC_R, rate_pending = 0, and pending register = CIC_R.
REQ-031 SHALL abort a partial frame on reset mid-frame with no output; the first output after release follows CIC_R strobes.

Verification
REQ-032 SHALL cover basic decimation: CIC_R=4, inputs 1,2,3,...,12 on consecutive clks -> samp_out_data 4, 8, 12, each with a 1-clk samp_out_str one clk after the strobe of 4, 8 and 12.
REQ-033 SHALL cover sparse strobes: ratio 3, strobes every 5 clks carrying -5,-6,-7 -> a single output -7, 1 clk after the third strobe; the counter is unaffected by the idle clks.
REQ-034 SHALL cover a rate change mid-frame: ratio 4, rate_str with 2 after 1 input -> rate_pending=1 until the 4th input, outputs at inputs 4, 6, 8 -> rate_active=2 after input 4.
REQ-035 SHALL cover clamping: rate_str with 0 -> rate_active 1 at the next boundary, every sample output; rate_str with CIC_R_MAX+3 -> rate_active = CIC_R_MAX.
REQ-036 SHALL cover phase_sync: ratio 4, phase_sync together with input 2 after input 1 -> the next outputs are inputs 5, 9.
REQ-037 SHALL cover reset: reset_n pulsed low mid-frame for 1 clk while samp_out_str=1 -> all outputs 0 asynchronously, rate_active=CIC_R, first output is the 4th strobe after release.
